// File: rtl/uart_echo_fifo.sv
// Byte FIFO between the UART receiver and transmitter: buffers received bytes
// and replays them to the transmitter in order through the TX_En/TX_Done handshake.
module uart_echo_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  RX_Done_Sig,
    input  logic [DATA_W-1:0]     RX_Data,
    input  logic                  TX_Done_Sig,
    output logic                  TX_En_Sig,
    output logic [DATA_W-1:0]     TX_Data,
    output logic [DATA_W-1:0]     LED_Out,
    output logic [DEPTH_LOG2:0]   Fifo_Count,
    output logic                  Overflow_Flag,
    input  logic                  Clr_Ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t                 state;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic                   rd_evt;
    logic                   wr_evt;
    logic                   drop;

    // A read in the same cycle frees a slot, so a full FIFO still accepts that byte.
    assign rd_evt = (state == LOAD);
    assign wr_evt = RX_Done_Sig && ((Fifo_Count < FULL_CNT) || rd_evt);
    assign drop   = RX_Done_Sig && !wr_evt;

    // NOTE: storage is deliberately left out of reset so it can map onto RAM;
    // the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_evt) begin
            mem[wr_ptr] <= RX_Data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, which the same-cycle read/write case depends on.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr        <= '0;
            Fifo_Count    <= '0;
            LED_Out       <= '0;
            Overflow_Flag <= 1'b0;
        end else begin
            if (RX_Done_Sig) begin
                LED_Out <= RX_Data;
            end
            if (wr_evt) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_evt, rd_evt})
                2'b10:   Fifo_Count <= Fifo_Count + 1'b1;
                2'b01:   Fifo_Count <= Fifo_Count - 1'b1;
                default: Fifo_Count <= Fifo_Count;
            endcase
            if (drop) begin
                Overflow_Flag <= 1'b1;
            end else if (Clr_Ovf) begin
                Overflow_Flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            TX_En_Sig <= 1'b0;
            TX_Data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    TX_En_Sig <= 1'b0;
                    if (Fifo_Count != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    TX_Data   <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + 1'b1;
                    TX_En_Sig <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (TX_Done_Sig) begin
                        TX_En_Sig <= 1'b0;
                        state     <= GAP;
                    end
                end
                // One guaranteed low cycle before the next request can start.
                GAP: begin
                    TX_En_Sig <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    TX_En_Sig <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
